sha256_round_sched: RTL and testbench



---
 rtl/sha256_round_sched.sv | 147 ++++++++++++++
 tb/tb_sha256_round_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_sched.sv
// SHA-256 round sequencer / message scheduler: loads 16 words, then emits K_t + W_t per round.
// Optional abort input is enabled by defining SHA256_SCHED_ABORT_EN.
module sha256_round_sched #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start,
    input  logic [31:0] w_in,
    input  logic        w_in_valid,
    output logic        w_in_ready,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] kw_out,
    output logic        kw_valid,
    input  logic        kw_ready,
    output logic [5:0]  round_idx,
    output logic        first_round,
    output logic        last_round,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    state_t             state_q, state_d;
    logic [5:0]         t_q, t_d;
    logic [3:0]         ld_cnt_q, ld_cnt_d;
    logic [15:0][31:0]  win_q, win_d;

    logic               shift_en;
    logic [31:0]        shift_word;
    logic [31:0]        w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Slot 0 always holds W_t for the current round, so the next word W_{t+16} uses slots 14/9/1/0.
    assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        ld_cnt_d   = ld_cnt_q;
        win_d      = win_q;
        shift_en   = 1'b0;
        shift_word = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_in_valid) begin
                    shift_en   = 1'b1;
                    shift_word = w_in;
                    ld_cnt_d   = ld_cnt_q + 4'd1;
                    if (ld_cnt_q == 4'd15) begin
                        state_d = ST_ROUND;
                        t_d     = 6'd0;
                    end
                end
            end
            ST_ROUND: begin
                if (kw_ready) begin
                    shift_en   = 1'b1;
                    shift_word = w_next;
                    if (t_q == LAST_T) begin
                        state_d = ST_DONE;
                        t_d     = 6'd0;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = shift_word;
        end

`ifdef SHA256_SCHED_ABORT_EN
        // Abort also masks a coincident start while idle.
        if (abort) begin
            state_d  = ST_IDLE;
            t_d      = 6'd0;
            ld_cnt_d = 4'd0;
            win_d    = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            t_q      <= 6'd0;
            ld_cnt_q <= 4'd0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            ld_cnt_q <= ld_cnt_d;
            win_q    <= win_d;
        end
    end

    assign w_in_ready  = (state_q == ST_LOAD);
    assign kw_valid    = (state_q == ST_ROUND);
    assign rom_addr    = t_q;
    assign round_idx   = t_q;
    assign kw_out      = rom_data + win_q[0];
    assign first_round = kw_valid && (t_q == 6'd0);
    assign last_round  = kw_valid && (t_q == LAST_T);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_sha256_round_sched.sv
// Bench for sha256_round_sched: directed "abc" vectors plus randomized blocks against a full-schedule model.
module tb_sha256_round_sched;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] w_in;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] kw_out;
    logic        kw_valid;
    logic        kw_ready;
    logic [5:0]  round_idx;
    logic        first_round;
    logic        last_round;
    logic        busy;
    logic        done;
`ifdef SHA256_SCHED_ABORT_EN
    logic        abort;
`endif

    logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    assign rom_data = K[rom_addr];

    sha256_round_sched #(.NUM_ROUNDS(N)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SHA256_SCHED_ABORT_EN
        .abort       (abort),
`endif
        .start       (start),
        .w_in        (w_in),
        .w_in_valid  (w_in_valid),
        .w_in_ready  (w_in_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .kw_out      (kw_out),
        .kw_valid    (kw_valid),
        .kw_ready    (kw_ready),
        .round_idx   (round_idx),
        .first_round (first_round),
        .last_round  (last_round),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [31:0] kw;
    } vec_t;

    vec_t        abc_vec [5];
    logic [31:0] blk     [16];
    logic [31:0] exp_kw  [64];
    logic [31:0] obs_kw  [64];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          busy_cyc;
    int          gaps;
    int          stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole schedule array from the standard recurrence, then KW = K + W.
    task automatic build_model();
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = blk[t];
            end else begin
                s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            exp_kw[t] = K[t] + w[t];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
    endtask

    // gap_mode: 0 continuous, 1 alternating, 2 random
    task automatic load_block(input int gap_mode, input bit poke_start);
        int acc;
        int cyc;
        bit v;
        busy_cyc = 0;
        gaps     = 0;
        stalls   = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        acc   = 0;
        cyc   = 0;
        while (acc < 16) begin
            if (!w_in_ready || cyc > 200) begin
                check("load_ready", {31'd0, w_in_ready}, 32'd1);
                break;
            end
            busy_cyc++;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            if (!v) gaps++;
            w_in_valid = v;
            w_in       = v ? blk[acc] : $urandom;
            start      = poke_start && ($urandom_range(0, 2) == 0);
            tick();
            if (v) acc++;
            cyc++;
        end
        w_in_valid = 1'b0;
        start      = 1'b0;
        check("ready_low_after_16", {31'd0, w_in_ready}, 32'd0);
        check("kw_valid_after_load", {31'd0, kw_valid}, 32'd1);
    endtask

    // stall_mode: 0 none, 1 stall_len cycles at stall_at, 2 random.
    // cut_at >= 0 stops the block at that round with rst (use_abort=0) or abort (use_abort=1).
    task automatic run_rounds(input int stall_mode, input int stall_at, input int stall_len,
                              input int cut_at, input bit use_abort, input bit poke_start);
        int t;
        int cyc;
        int held;
        bit r;
        t    = 0;
        cyc  = 0;
        held = 0;
        while (t < N) begin
            if (!kw_valid || cyc > 1000) begin
                check("kw_valid_in_round", {31'd0, kw_valid}, 32'd1);
                return;
            end
            busy_cyc++;
            obs_kw[t] = kw_out;
            check($sformatf("kw_t%0d", t), kw_out, exp_kw[t]);
            check("round_idx", {26'd0, round_idx}, t);
            check("rom_addr", {26'd0, rom_addr}, t);
            check("first_round", {31'd0, first_round}, {31'd0, (t == 0)});
            check("last_round", {31'd0, last_round}, {31'd0, (t == N - 1)});
            check("done_in_round", {31'd0, done}, 32'd0);
            if (t == cut_at) begin
                kw_ready = 1'b1;
`ifdef SHA256_SCHED_ABORT_EN
                if (use_abort) abort = 1'b1;
                else rst = 1'b1;
`else
                if (!use_abort) rst = 1'b1;
`endif
                tick();
                rst      = 1'b0;
                kw_ready = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
                abort = 1'b0;
`endif
                return;
            end
            case (stall_mode)
                0:       r = 1'b1;
                1:       r = !(t == stall_at && held < stall_len);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            if (!r) begin
                stalls++;
                held++;
            end
            kw_ready = r;
            start    = poke_start && ($urandom_range(0, 3) == 0);
            tick();
            if (r) t++;
            cyc++;
        end
        kw_ready = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("kw_valid_in_done", {31'd0, kw_valid}, 32'd0);
        busy_cyc++;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("start_in_done_ignored", {31'd0, w_in_ready}, 32'd0);
        check("block_latency", busy_cyc, 16 + N + 1 + gaps + stalls);
    endtask

    task automatic check_abc_table(input string tag);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_abc_t%0d", tag, abc_vec[i].t), obs_kw[abc_vec[i].t], abc_vec[i].kw);
        end
    endtask

    task automatic check_idle_after_cut();
        check("cut_busy", {31'd0, busy}, 32'd0);
        check("cut_kw_valid", {31'd0, kw_valid}, 32'd0);
        check("cut_done", {31'd0, done}, 32'd0);
        check("cut_round_idx", {26'd0, round_idx}, 32'd0);
        check("cut_kw_out_cleared", kw_out, K[0]);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cut_no_done", {31'd0, done}, 32'd0);
            check("cut_stays_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        abc_vec[0] = '{0,  32'hA3EC9318};
        abc_vec[1] = '{1,  32'h71374491};
        abc_vec[2] = '{15, 32'hC19BF18C};
        abc_vec[3] = '{16, 32'h45FDCD41};
        abc_vec[4] = '{17, 32'hEFCD4786};

        rst        = 1'b1;
        start      = 1'b0;
        w_in       = 32'd0;
        w_in_valid = 1'b0;
        kw_ready   = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
        abort      = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_kw_valid", {31'd0, kw_valid}, 32'd0);
        check("rst_w_in_ready", {31'd0, w_in_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rom_addr", {26'd0, rom_addr}, 32'd0);
        check("rst_kw_out", kw_out, K[0]);
        tick();

        // "abc" with continuous handshakes
        set_abc();
        load_block(0, 1'b0);
        run_rounds(0, 0, 0, -1, 1'b0, 1'b0);
        check_abc_table("plain");

        // 3-cycle stall at t = 16
        load_block(0, 1'b0);
        run_rounds(1, 16, 3, -1, 1'b0, 1'b0);
        check("stall_count", stalls, 3);
        check_abc_table("stall");

        // alternating load gaps with stray start pulses
        load_block(1, 1'b1);
        run_rounds(0, 0, 0, -1, 1'b0, 1'b1);
        check_abc_table("gaps");

        // reset mid-round, then a clean reload
        load_block(0, 1'b0);
        run_rounds(0, 0, 0, 30, 1'b0, 1'b0);
        check_idle_after_cut();
        load_block(0, 1'b0);
        run_rounds(0, 0, 0, -1, 1'b0, 1'b0);
        check_abc_table("after_rst");

`ifdef SHA256_SCHED_ABORT_EN
        load_block(0, 1'b0);
        run_rounds(0, 0, 0, 10, 1'b1, 1'b0);
        check_idle_after_cut();
        load_block(2, 1'b0);
        run_rounds(2, 0, 0, -1, 1'b0, 1'b0);
        check_abc_table("after_abort");
`endif

        // random blocks with random load gaps and kw_ready stalls
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            build_model();
            load_block(2, 1'b1);
            run_rounds(2, 0, 0, -1, 1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
